reg_access_arbiter: RTL

//  Shares the PID register file's single write/read port between two requesters (0: host UART

---
 rtl/pid_regmap_pkg.sv | 30 +++
 rtl/reg_access_arbiter_rr_arb2.sv | 27 ++
 rtl/reg_access_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pid_regmap_pkg.sv
// -----------------------------------------------------------------------------
// pid_regmap_pkg
// Register map of the PID register file and the state encoding of the access
// arbiter that drives its single byte port. The register file itself imports
// this package, so both sides share one definition of the map.
//   REG_P..REG_SP     : writable tuning registers
//   REG_PID_O, REG_PWM_O : live outputs, refreshed by the register file
//   NUM_REGS          : implemented registers; higher addresses are illegal
//   RO_BASE           : first register that is read-only
// -----------------------------------------------------------------------------
package pid_regmap_pkg;

  localparam int REG_P     = 0;
  localparam int REG_I     = 1;
  localparam int REG_D     = 2;
  localparam int REG_SP    = 3;
  localparam int REG_PID_O = 14;
  localparam int REG_PWM_O = 15;
  localparam int NUM_REGS  = 16;
  localparam int RO_BASE   = 14;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    RESP
  } state_e;

endpackage : pid_regmap_pkg

// File: rtl/reg_access_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. With a single request that requester wins; with
// both, the one that did not win last time wins.
//   req[1:0]    in  : request vector
//   last_grant  in  : index of the previously granted requester
//   gnt[1:0]    out : one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_arb2

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
// Shares the PID register file's single write/read byte port between the host
// UART command parser (requester 0) and the debug/SPI bridge (requester 1).
// One transaction is in flight at a time: accept, check the address, perform
// the write or the registered read, then pulse a response to the requester.
//
// Ports
//   clk_in, reset                 : clock, asynchronous active-high reset
//   reqN_valid/ready/we/addr/wdata: request handshake, N = 0,1
//   rspN_valid/rdata/err          : one-cycle response pulse, N = 0,1
//   mem_we/waddr/wdata/raddr      : register-file port (drive side)
//   mem_rdata                     : register-file read data, 1 cycle after raddr
//
// Latency from the accept cycle T: write response T+2, read T+3, error T+1.
//
// Build option: define REG_WR_PROTECT_EN to reject writes to the read-only
// registers [RO_BASE, NUM_REGS). Without it those writes reach the register
// file, which overwrites them from live PID/PWM values on the next cycle.
// -----------------------------------------------------------------------------
module reg_access_arbiter
  import pid_regmap_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = pid_regmap_pkg::NUM_REGS,
  parameter int RO_BASE  = pid_regmap_pkg::RO_BASE
) (
  input  logic              clk_in,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e                 state_q, state_d;
  logic                   id_q, id_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   last_grant_q, last_grant_d;
  logic                   mem_we_q, mem_we_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [1:0][DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  logic              sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Ready is only offered from IDLE, so the grant is a handshake in that cycle.
  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & gnt[0];
  assign req1_ready = idle & gnt[1];
  assign accept     = idle & (|gnt);

  assign sel_id    = gnt[1];
  assign sel_we    = sel_id ? req1_we    : req0_we;
  assign sel_addr  = sel_id ? req1_addr  : req0_addr;
  assign sel_wdata = sel_id ? req1_wdata : req0_wdata;

  // The check is evaluated on the request being latched, so an illegal access
  // can be answered in the very next cycle without touching the register file.
  always_comb begin
    sel_legal = (int'(sel_addr) < NUM_REGS);
`ifdef REG_WR_PROTECT_EN
    if (sel_we && (int'(sel_addr) >= RO_BASE)) begin
      sel_legal = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    mem_we_d     = 1'b0;
    rsp_valid_d  = 2'b00;
    rsp_err_d    = 2'b00;
    rsp_rdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d         = sel_id;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          last_grant_d = sel_id;
          if (!sel_legal) begin
            rsp_valid_d[sel_id] = 1'b1;
            rsp_err_d[sel_id]   = 1'b1;
            state_d             = RESP;
          end else if (sel_we) begin
            mem_we_d = 1'b1;
            state_d  = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        rsp_valid_d[id_q] = 1'b1;
        state_d           = RESP;
      end
      READ: begin
        // mem_raddr already carries the latched address during this cycle.
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        rsp_valid_d[id_q] = 1'b1;
        rsp_rdata_d[id_q] = mem_rdata;
        state_d           = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      mem_we_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 2'b00;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // Address/data follow the latched request; only mem_we qualifies the write.
  assign mem_we    = mem_we_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_raddr = addr_q;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp1_rdata = rsp_rdata_q[1];

endmodule : reg_access_arbiter
